// File: rtl/spi_slave_if.sv
// SPI slave front end: deserialises {cmd[1:0], payload} frames for the RAM stage and
// shifts the RAM read word back out on MISO. Define SPI_FRAME_ERR_EN to add the frame_err abort strobe.
module spi_slave_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid
`ifdef SPI_FRAME_ERR_EN
  ,
  output logic              frame_err
`endif
);

  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;

  localparam logic [CNT_W-1:0] RX_BITS = CNT_W'(DATA_W + 2);
  localparam logic [CNT_W-1:0] TX_BITS = CNT_W'(DATA_W);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W+1:0] rx_sh;
  logic [DATA_W-1:0] tx_sh;
  logic              rd_addr_done;
  logic              rx_done;
  logic              tx_busy;
  logic              tx_done;
  logic              shifting;
  logic              rx_shift;
  logic              rx_last;

  assign shifting = (state == WRITE) || (state == READ_ADD) || (state == READ_DATA);
  assign rx_shift = shifting && !rx_done && (cnt != RX_BITS);
  // A frame whose last bit has landed is delivered even if SS_n rises on the very next edge.
  assign rx_last  = shifting && !rx_done && (cnt == RX_BITS);

`ifdef SPI_FRAME_ERR_EN
  logic abort_err;
  assign abort_err = (state == CHK_CMD) || (shifting && !rx_done && !rx_last) ||
                     ((state == READ_DATA) && !tx_done);
`endif

  always_ff @(posedge clk)
    if (rx_shift) rx_sh <= {rx_sh[DATA_W:0], MOSI};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      MISO         <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      cnt          <= '0;
      rd_addr_done <= 1'b0;
      tx_sh        <= '0;
      rx_done      <= 1'b0;
      tx_busy      <= 1'b0;
      tx_done      <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
      frame_err    <= 1'b0;
`endif
    end else begin
      rx_valid <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
      frame_err <= 1'b0;
`endif
      if (rx_last) begin
        rx_data  <= rx_sh;
        rx_valid <= 1'b1;
        rx_done  <= 1'b1;
        if (state == READ_ADD) rd_addr_done <= 1'b1;
      end

      if ((state != IDLE) && SS_n) begin
        state   <= IDLE;
        cnt     <= '0;
        MISO    <= 1'b0;
        rx_done <= 1'b0;
        tx_busy <= 1'b0;
        tx_done <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
        frame_err <= abort_err;
`endif
      end else begin
        case (state)
          IDLE: begin
            if (!SS_n) begin
              state <= CHK_CMD;
              cnt   <= '0;
            end
          end
          CHK_CMD: begin
            cnt     <= '0;
            rx_done <= 1'b0;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
            if (!MOSI)             state <= WRITE;
            else if (rd_addr_done) state <= READ_DATA;
            else                   state <= READ_ADD;
          end
          default: begin
            if (rx_shift) cnt <= cnt + 1'b1;
            // The RAM answers only after it has seen the rx_valid strobe.
            if ((state == READ_DATA) && rx_done && !rx_valid && !tx_busy && !tx_done && tx_valid) begin
              tx_sh   <= tx_data;
              tx_busy <= 1'b1;
              cnt     <= '0;
            end
            if (tx_busy) begin
              if (cnt == TX_BITS) begin
                MISO         <= 1'b0;
                tx_busy      <= 1'b0;
                tx_done      <= 1'b1;
                rd_addr_done <= 1'b0;
              end else begin
                MISO  <= tx_sh[DATA_W-1];
                tx_sh <= tx_sh << 1;
                cnt   <= cnt + 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: a frame-level timing model fills per-cycle expectations,
// one negedge process compares them, and literal pins anchor the model.
`timescale 1ns/1ps
module tb_spi_slave_if;
  localparam int DW = 8;
  localparam int N  = 1024;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          SS_n = 1'b1;
  logic          MOSI = 1'b0;
  logic          tx_valid = 1'b0;
  logic [DW-1:0] tx_data = '0;
  logic          MISO;
  logic          rx_valid;
  logic [DW+1:0] rx_data;
`ifdef SPI_FRAME_ERR_EN
  logic          frame_err;
  bit            exp_ferr [N];
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit rst_seen = 1'b0;

  bit         exp_rxv [N];
  logic [9:0] exp_word [N];
  bit         exp_miso [N];
  bit         lit_rxd_en [N];
  logic [9:0] lit_rxd [N];
  bit         lit_byte_en [N];
  int         lit_base [N];
  logic [7:0] lit_byte [N];
  bit         miso_hist [N];
  logic [9:0] model_rxd = '0;
  bit         m_rd_done = 1'b0;

  always #5 clk = ~clk;

  spi_slave_if #(.DATA_W(DW), .CNT_W(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .SS_n(SS_n),
    .MOSI(MOSI),
    .MISO(MISO),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .tx_data(tx_data),
    .tx_valid(tx_valid)
`ifdef SPI_FRAME_ERR_EN
    , .frame_err(frame_err)
`endif
  );

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= !rst_n;
  end

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, req);
    end
  endtask

  always @(negedge clk) begin : compare
    logic [7:0] b;
    if (cyc > 0 && cyc < N) begin
      miso_hist[cyc] = MISO;
      if (rst_seen) model_rxd = '0;
      else if (exp_rxv[cyc]) model_rxd = exp_word[cyc];
      chk("rx_valid", {9'b0, rx_valid}, {9'b0, exp_rxv[cyc] && !rst_seen});
      chk("rx_data", rx_data, model_rxd);
      chk("miso", {9'b0, MISO}, {9'b0, exp_miso[cyc] && !rst_seen});
`ifdef SPI_FRAME_ERR_EN
      chk("frame_err", {9'b0, frame_err}, {9'b0, exp_ferr[cyc] && !rst_seen});
`endif
      if (lit_rxd_en[cyc]) chk("rx_data_pin", rx_data, lit_rxd[cyc]);
      if (lit_byte_en[cyc]) begin
        b = '0;
        for (int k = 0; k < 8; k++) b = {b[6:0], miso_hist[lit_base[cyc] + k]};
        chk("miso_byte_pin", {2'b0, b}, {2'b0, lit_byte[cyc]});
      end
    end
  end

  task automatic pin_rxd(input logic [9:0] v);
    lit_rxd_en[cyc + 1] = 1'b1;
    lit_rxd[cyc + 1]    = v;
  endtask

  task automatic pin_byte(input int base, input logic [7:0] v);
    lit_byte_en[cyc + 1] = 1'b1;
    lit_base[cyc + 1]    = base;
    lit_byte[cyc + 1]    = v;
  endtask

  // One SS_n-framed transaction; abort_n >= 0 raises SS_n after that many shifted bits,
  // txd >= 1 pulses tx_valid txd cycles after rx_valid, rst_bit > 0 resets during that MISO bit.
  task automatic frame(input logic [9:0] w, input int abort_n, input int txd,
                       input logic [7:0] txw, input int rst_bit, output int l_out);
    int c;
    int l;
    bit rd_data;
    l_out = -1;
    @(negedge clk);
    c = cyc;
    SS_n = 1'b0;
    MOSI = 1'b0;
    rd_data = w[9] && m_rd_done;
    @(negedge clk);
    MOSI = w[9];
    for (int i = 9; i >= 0; i--) begin
      if (abort_n == 9 - i) break;
      @(negedge clk);
      MOSI = w[i];
    end
    if (abort_n >= 0) begin
      @(negedge clk);
      SS_n = 1'b1;
      MOSI = 1'b0;
`ifdef SPI_FRAME_ERR_EN
      exp_ferr[c + 3 + abort_n] = 1'b1;
`endif
      @(negedge clk);
      return;
    end
    @(negedge clk);
    MOSI = 1'b0;
    exp_rxv[c + 13]  = 1'b1;
    exp_word[c + 13] = w;
    if (w[9] && !rd_data) m_rd_done = 1'b1;
    if (txd >= 1) begin
      while (cyc < c + 13 + txd) @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = txw;
      l = c + 14 + txd;
      if (rd_data) begin
        for (int k = 1; k <= 8; k++) exp_miso[l + k] = txw[8 - k];
        l_out = l;
      end
      @(negedge clk);
      tx_valid = 1'b0;
      tx_data  = '0;
      if (rd_data && rst_bit > 0) begin
        while (cyc < l + rst_bit) @(negedge clk);
        rst_n = 1'b0;
        SS_n  = 1'b1;
        for (int k = rst_bit + 1; k <= 8; k++) exp_miso[l + k] = 1'b0;
        m_rd_done = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      while (cyc < l + 10) @(negedge clk);
      if (rd_data) m_rd_done = 1'b0;
    end else begin
      while (cyc < c + 15) @(negedge clk);
    end
    SS_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int l;
    rst_n = 1'b0;
    SS_n  = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    pin_rxd(10'h000);
    frame(10'h03C, -1, 0, 8'h00, 0, l); pin_rxd(10'h03C);
    frame(10'h1A5, -1, 0, 8'h00, 0, l); pin_rxd(10'h1A5);
    frame(10'h23C, -1, 1, 8'hFF, 0, l); pin_rxd(10'h23C);
    frame(10'h300, -1, 1, 8'hA5, 0, l); pin_byte(l + 1, 8'hA5);
    frame(10'h1FF,  5, 0, 8'h00, 0, l); pin_rxd(10'h300);
    frame(10'h377, -1, 2, 8'h81, 0, l); pin_rxd(10'h377);
    frame(10'h3C3, -1, 3, 8'h6E, 6, l); pin_rxd(10'h000);
    frame(10'h2A9, -1, 1, 8'hFF, 0, l); pin_rxd(10'h2A9);
    frame(10'h3F0, -1, 1, 8'h3C, 0, l); pin_byte(l + 1, 8'h3C);
    frame(10'h0AA,  9, 0, 8'h00, 0, l); pin_rxd(10'h3F0);
    frame(10'h155,  0, 0, 8'h00, 0, l); pin_rxd(10'h3F0);
    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
